// File: rtl/dreg_pipe.sv
// rtl/dreg_pipe.sv - parametrised delay-line register chain with per-stage valid, flush and occupancy count (optional DREG_PIPE_ZEROGATE_EN)
module dreg_pipe #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk50m,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic                         clr,
   input  logic [W-1:0]                 d,
   input  logic                         d_valid,
   output logic [W-1:0]                 q,
   output logic                         q_valid,
   output logic [$clog2(DEPTH+1)-1:0]   occ
);

   localparam int OW = $clog2(DEPTH+1);

   logic [W-1:0]     stage [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [W-1:0]     d_in;
   logic [OW-1:0]    occ_next;

   // Data entering stage 0; the gated build forces invalid entries to zero
   always_comb begin
`ifdef DREG_PIPE_ZEROGATE_EN
      d_in = d_valid ? d : '0;
`else
      d_in = d;
`endif
   end

   // Running count: one word enters and the last-stage word leaves per shift
   always_comb begin
      occ_next = occ + OW'(d_valid) - OW'(vld[DEPTH-1]);
   end

   // Stage chain: reset/flush clear everything, load shifts by one, else hold
   always_ff @(posedge clk50m) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
         vld <= '0;
         occ <= '0;
      end else if (load) begin
         stage[0] <= d_in;
         vld[0]   <= d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
            vld[i]   <= vld[i-1];
         end
         occ <= occ_next;
      end
   end

   assign q       = stage[DEPTH-1];
   assign q_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_dreg_pipe.sv
// tb/tb_dreg_pipe.sv - scoreboard bench for dreg_pipe with a queue-based reference model
module tb_dreg_pipe;

   localparam int W     = 16;
   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH+1);

   logic          clk50m = 1'b0;
   logic          rst_n  = 1'b0;
   logic          load   = 1'b0;
   logic          clr    = 1'b0;
   logic [W-1:0]  d      = '0;
   logic          d_valid = 1'b0;
   logic [W-1:0]  q;
   logic          q_valid;
   logic [OW-1:0] occ;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         v;
   } ent_t;

   typedef struct {
      logic [W-1:0]  q;
      logic          qv;
      logic [OW-1:0] occ;
   } exp_t;

   ent_t pipe[$];
   exp_t exp_q[$];

   dreg_pipe #(.W(W), .DEPTH(DEPTH)) dut (
      .clk50m  (clk50m),
      .rst_n   (rst_n),
      .load    (load),
      .clr     (clr),
      .d       (d),
      .d_valid (d_valid),
      .q       (q),
      .q_valid (q_valid),
      .occ     (occ)
   );

   always #10 clk50m = ~clk50m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference: the pipe is a list of DEPTH entries, newest first
   task automatic model_edge(input logic r, input logic l, input logic c,
                             input logic [W-1:0] dd, input logic dv);
      ent_t e;
      exp_t x;
      int   cnt;
      if (!r || c) begin
         pipe.delete();
         for (int i = 0; i < DEPTH; i++) begin
            e.data = '0; e.v = 1'b0;
            pipe.push_back(e);
         end
      end else if (l) begin
`ifdef DREG_PIPE_ZEROGATE_EN
         e.data = dv ? dd : '0;
`else
         e.data = dd;
`endif
         e.v = dv;
         pipe.push_front(e);
         void'(pipe.pop_back());
      end
      cnt = 0;
      foreach (pipe[i]) if (pipe[i].v) cnt++;
      x.q   = pipe[DEPTH-1].data;
      x.qv  = pipe[DEPTH-1].v;
      x.occ = OW'(cnt);
      exp_q.push_back(x);
   endtask

   task automatic step(input logic r, input logic l, input logic c,
                       input logic [W-1:0] dd, input logic dv);
      @(negedge clk50m);
      rst_n = r; load = l; clr = c; d = dd; d_valid = dv;
      @(posedge clk50m);
      model_edge(r, l, c, dd, dv);
   endtask

   // Monitor: every settled output is compared against the oldest expectation
   always @(negedge clk50m) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("sb_q",       32'(q),       32'(e.q));
         check("sb_q_valid", 32'(q_valid), 32'(e.qv));
         check("sb_occ",     32'(occ),     32'(e.occ));
      end
   end

   initial begin
      // Reset with active-looking inputs
      step(1'b0, 1'b1, 1'b0, 16'hffff, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'hffff, 1'b1);
      #1;
      check("rst_q",   32'(q), 32'h0);
      check("rst_occ", 32'(occ), 32'h0);

      // Fill
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, W'(i), 1'b1);
      #1;
      check("fill_q",   32'(q), 32'h0001);
      check("fill_qv",  32'(q_valid), 32'h1);
      check("fill_occ", 32'(occ), 32'h4);
      step(1'b1, 1'b1, 1'b0, 16'h0005, 1'b1);
      #1;
      check("fill_q2", 32'(q), 32'h0002);

      // Stall then resume
      repeat (3) step(1'b1, 1'b0, 1'b0, 16'haaff, 1'b1);
      #1;
      check("stall_q", 32'(q), 32'h0002);
      for (int i = 6; i <= 7; i++) step(1'b1, 1'b1, 1'b0, W'(i), 1'b1);
      #1;
      check("resume_q", 32'(q), 32'h0004);

      // Bubbles
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, W'(16'h0010 + i), (i % 2) == 0);
      #1;
      check("bubble_occ", 32'(occ), 32'h2);

      // Flush with load
      step(1'b1, 1'b1, 1'b1, 16'hffaa, 1'b1);
      #1;
      check("flush_q",   32'(q), 32'h0);
      check("flush_qv",  32'(q_valid), 32'h0);
      check("flush_occ", 32'(occ), 32'h0);

      // Invalid words carry data or zero depending on build
      repeat (4) step(1'b1, 1'b1, 1'b0, 16'hffaa, 1'b0);
      #1;
`ifdef DREG_PIPE_ZEROGATE_EN
      check("gate_q", 32'(q), 32'h0000);
`else
      check("gate_q", 32'(q), 32'hffaa);
`endif
      check("gate_qv", 32'(q_valid), 32'h0);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 99) < 3),
              W'($urandom),
              1'($urandom));
      end

      // Drain scoreboard
      repeat (3) @(negedge clk50m);
      #1;
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
